// File: rtl/ram_write_arbiter.sv
// Round-robin arbiter sharing one RAM write port between two sample producers.
// Each accepted word gets its channel's wrapping region address and a 3-cycle write sequence.
module ram_write_arbiter #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned CH0_BASE = 1,
    parameter int unsigned CH0_LAST = 8191,
    parameter int unsigned CH1_BASE = 8192,
    parameter int unsigned CH1_LAST = 16383
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [DATA_W-1:0]     i_req0_data,
    input  logic [DATA_W/8-1:0]   i_req0_byteen,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [DATA_W-1:0]     i_req1_data,
    input  logic [DATA_W/8-1:0]   i_req1_byteen,
    output logic [DATA_W-1:0]     o_data,
    output logic [ADDR_W-1:0]     o_address,
    output logic [DATA_W/8-1:0]   o_byteen,
    output logic                  o_wbit,
    output logic [ADDR_W-1:0]     o_ptr0,
    output logic [ADDR_W-1:0]     o_ptr1,
    output logic                  o_wrap0,
    output logic                  o_wrap1
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] Ch0Base = ADDR_W'(CH0_BASE);
    localparam logic [ADDR_W-1:0] Ch0Last = ADDR_W'(CH0_LAST);
    localparam logic [ADDR_W-1:0] Ch1Base = ADDR_W'(CH1_BASE);
    localparam logic [ADDR_W-1:0] Ch1Last = ADDR_W'(CH1_LAST);

    typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr0_q, ptr0_d, ptr1_q, ptr1_d, addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                last_q, last_d;
    logic                wbit_q, wbit_d, wrap0_q, wrap0_d, wrap1_q, wrap1_d;
    logic                grant0, grant1;

    // last_q holds the channel granted last; on a tie the other one wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle && !i_rst) begin
            grant0 = i_req0_valid && (!i_req1_valid || last_q);
            grant1 = i_req1_valid && (!i_req0_valid || !last_q);
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    always_comb begin
        state_d = state_q;
        ptr0_d  = ptr0_q;
        ptr1_d  = ptr1_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        last_d  = last_q;
        wbit_d  = 1'b0;
        wrap0_d = 1'b0;
        wrap1_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant0) begin
                    data_d  = i_req0_data;
                    be_d    = i_req0_byteen;
                    addr_d  = ptr0_q;
                    ptr0_d  = (ptr0_q == Ch0Last) ? Ch0Base : ptr0_q + 1'b1;
                    last_d  = 1'b0;
                    wbit_d  = 1'b1;
                    wrap0_d = (ptr0_q == Ch0Last);
                    state_d = StWrite;
                end else if (grant1) begin
                    data_d  = i_req1_data;
                    be_d    = i_req1_byteen;
                    addr_d  = ptr1_q;
                    ptr1_d  = (ptr1_q == Ch1Last) ? Ch1Base : ptr1_q + 1'b1;
                    last_d  = 1'b1;
                    wbit_d  = 1'b1;
                    wrap1_d = (ptr1_q == Ch1Last);
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StHold;
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            ptr0_q  <= Ch0Base;
            ptr1_q  <= Ch1Base;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            last_q  <= 1'b1;
            wbit_q  <= 1'b0;
            wrap0_q <= 1'b0;
            wrap1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr0_q  <= ptr0_d;
            ptr1_q  <= ptr1_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            last_q  <= last_d;
            wbit_q  <= wbit_d;
            wrap0_q <= wrap0_d;
            wrap1_q <= wrap1_d;
        end
    end

    assign o_data    = data_q;
    assign o_address = addr_q;
    assign o_byteen  = be_q;
    assign o_wbit    = wbit_q;
    assign o_ptr0    = ptr0_q;
    assign o_ptr1    = ptr1_q;
    assign o_wrap0   = wrap0_q;
    assign o_wrap1   = wrap1_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Bench for ram_write_arbiter: directed vector table, hand sequences, and random traffic
// checked against a transaction-level model of grants, addresses and write timing.
module tb_ram_write_arbiter;
    localparam int AW = 14;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int CH0_BASE = 1;
    localparam int CH0_LAST = 8191;
    localparam int CH1_BASE = 8192;
    localparam int CH1_LAST = 16383;
    localparam logic [DW-1:0] D0 = 64'h0003_0002_0001_0000;
    localparam logic [DW-1:0] D1 = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0, r0, r1;
    logic [DW-1:0] d0 = '0, d1 = '0, o_data;
    logic [BW-1:0] b0 = '0, b1 = '0, o_byteen;
    logic [AW-1:0] o_address, o_ptr0, o_ptr1;
    logic o_wbit, o_wrap0, o_wrap1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_write_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .CH0_BASE(CH0_BASE), .CH0_LAST(CH0_LAST),
        .CH1_BASE(CH1_BASE), .CH1_LAST(CH1_LAST)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_data(d0), .i_req0_byteen(b0),
        .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_data(d1), .i_req1_byteen(b1),
        .o_data(o_data), .o_address(o_address), .o_byteen(o_byteen), .o_wbit(o_wbit),
        .o_ptr0(o_ptr0), .o_ptr1(o_ptr1), .o_wrap0(o_wrap0), .o_wrap1(o_wrap1)
    );

    initial begin
        assert (CH0_BASE <= CH0_LAST && CH1_BASE <= CH1_LAST &&
                (CH0_LAST < CH1_BASE || CH1_LAST < CH0_BASE))
        else $fatal(1, "FAIL param_regions: channel regions overlap or are inverted");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int            cyc, acc_cyc, last_g, gen_cnt, wrap1_seen;
    int            cnt [2];
    logic          pv [2];
    logic [DW-1:0] pd [2];
    logic [BW-1:0] pb [2];
    logic          have_w;
    int            w_ch, w_addr;
    logic [DW-1:0] w_data;
    logic [BW-1:0] w_be;

    function automatic int exp_addr(input int ch, input int k);
        if (ch == 0) return CH0_BASE + k % (CH0_LAST - CH0_BASE + 1);
        return CH1_BASE + k % (CH1_LAST - CH1_BASE + 1);
    endfunction

    task automatic apply();
        v0 = pv[0]; d0 = pd[0]; b0 = pb[0];
        v1 = pv[1]; d1 = pd[1]; b1 = pb[1];
    endtask

    task automatic model_reset();
        cyc = 0; acc_cyc = -100; last_g = 1; gen_cnt = 0; wrap1_seen = 0;
        have_w = 1'b0; w_ch = 0; w_addr = 0; w_data = '0; w_be = '0;
        for (int c = 0; c < 2; c++) begin
            cnt[c] = 0; pv[c] = 1'b0; pd[c] = '0; pb[c] = '0;
        end
        apply();
    endtask

    // mode 0: random traffic, 1: channel 1 streaming only, 2: no new words
    task automatic step(input int mode);
        logic idle, er0, er1, wb;
        @(negedge clk);
        idle = (cyc >= acc_cyc + 3);
        er0  = idle && pv[0] && (!pv[1] || last_g == 1);
        er1  = idle && pv[1] && (!pv[0] || last_g == 0);
        wb   = (cyc == acc_cyc + 1);
        chk("m_ready0", r0, er0);
        chk("m_ready1", r1, er1);
        chk("m_wbit", o_wbit, wb);
        chk("m_address", o_address, have_w ? w_addr : 0);
        chk("m_data", o_data, have_w ? w_data : '0);
        chk("m_byteen", o_byteen, have_w ? w_be : '0);
        chk("m_wrap0", o_wrap0, wb && w_ch == 0 && w_addr == CH0_LAST);
        chk("m_wrap1", o_wrap1, wb && w_ch == 1 && w_addr == CH1_LAST);
        chk("m_ptr0", o_ptr0, exp_addr(0, cnt[0]));
        chk("m_ptr1", o_ptr1, exp_addr(1, cnt[1]));
        if (o_wrap1) wrap1_seen++;
        if (er0 || er1) begin
            w_ch   = er0 ? 0 : 1;
            w_addr = exp_addr(w_ch, cnt[w_ch]);
            w_data = pd[w_ch];
            w_be   = pb[w_ch];
            have_w = 1'b1;
            cnt[w_ch]++;
            last_g  = w_ch;
            acc_cyc = cyc;
            pv[w_ch] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (!pv[c]) begin
                if (mode == 0) pv[c] = ($urandom_range(0, 3) != 0);
                else if (mode == 1) pv[c] = (c == 1);
                if (pv[c]) begin
                    pd[c] = {$urandom, $urandom};
                    pb[c] = BW'($urandom);
                    gen_cnt++;
                end
            end
        end
        apply();
    endtask

    task automatic hw_reset(input logic hold_valid);
        @(posedge clk);
        #1;
        rst = 1'b1;
        v0 = hold_valid; v1 = hold_valid;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          v0, v1;
        logic          r0, r1, wbit;
        logic [AW-1:0] addr, p0, p1;
    } vec_t;

    vec_t vt [18];

    initial begin
        int n;
        logic [DW-1:0] exp_d;
        logic [BW-1:0] exp_b;

        vt[0]  = '{1, 1, 1, 0, 0, 0,    1, 8192};
        vt[1]  = '{1, 1, 0, 0, 1, 1,    2, 8192};
        vt[2]  = '{1, 1, 0, 0, 0, 1,    2, 8192};
        vt[3]  = '{1, 1, 0, 1, 0, 1,    2, 8192};
        vt[4]  = '{1, 1, 0, 0, 1, 8192, 2, 8193};
        vt[5]  = '{1, 1, 0, 0, 0, 8192, 2, 8193};
        vt[6]  = '{1, 1, 1, 0, 0, 8192, 2, 8193};
        vt[7]  = '{1, 1, 0, 0, 1, 2,    3, 8193};
        vt[8]  = '{1, 1, 0, 0, 0, 2,    3, 8193};
        vt[9]  = '{1, 1, 0, 1, 0, 2,    3, 8193};
        vt[10] = '{0, 0, 0, 0, 1, 8193, 3, 8194};
        vt[11] = '{0, 0, 0, 0, 0, 8193, 3, 8194};
        vt[12] = '{1, 0, 1, 0, 0, 8193, 3, 8194};
        vt[13] = '{0, 1, 0, 0, 1, 3,    4, 8194};
        vt[14] = '{0, 1, 0, 0, 0, 3,    4, 8194};
        vt[15] = '{0, 1, 0, 1, 0, 3,    4, 8194};
        vt[16] = '{0, 0, 0, 0, 1, 8194, 4, 8195};
        vt[17] = '{0, 0, 0, 0, 0, 8194, 4, 8195};

        // Reset with both producers asking: nothing may be granted while in reset.
        @(posedge clk);
        #1;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
        d0 = D0; b0 = 8'hFF; d1 = D1; b1 = 8'h0F;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready0", r0, 1'b0);
            chk("rst_ready1", r1, 1'b0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("rst_wbit", o_wbit, 1'b0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_addr", o_address, 0);
        chk("rst_byteen", o_byteen, 0);
        chk("rst_wrap0", o_wrap0, 1'b0);
        chk("rst_wrap1", o_wrap1, 1'b0);
        chk("rst_ptr0", o_ptr0, CH0_BASE);
        chk("rst_ptr1", o_ptr1, CH1_BASE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            v0 = vt[i].v0;
            v1 = vt[i].v1;
            @(negedge clk);
            chk($sformatf("vec%0d_ready0", i), r0, vt[i].r0);
            chk($sformatf("vec%0d_ready1", i), r1, vt[i].r1);
            chk($sformatf("vec%0d_wbit", i), o_wbit, vt[i].wbit);
            chk($sformatf("vec%0d_addr", i), o_address, vt[i].addr);
            chk($sformatf("vec%0d_ptr0", i), o_ptr0, vt[i].p0);
            chk($sformatf("vec%0d_ptr1", i), o_ptr1, vt[i].p1);
            if (vt[i].wbit) begin
                exp_d = (vt[i].addr < CH1_BASE) ? D0 : D1;
                exp_b = (vt[i].addr < CH1_BASE) ? 8'hFF : 8'h0F;
                chk($sformatf("vec%0d_data", i), o_data, exp_d);
                chk($sformatf("vec%0d_byteen", i), o_byteen, exp_b);
            end
            @(posedge clk);
            #1;
        end

        // Reset landing on the write cycle.
        hw_reset(1'b0);
        v0 = 1'b1; d0 = D0; b0 = 8'hFF;
        @(negedge clk);
        chk("rw_accept", r0, 1'b1);
        @(posedge clk);
        #1;
        v0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rw_wbit_pulse", o_wbit, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rw_wbit_after", o_wbit, 1'b0);
        chk("rw_ptr0", o_ptr0, CH0_BASE);
        chk("rw_ptr1", o_ptr1, CH1_BASE);
        chk("rw_addr", o_address, 0);
        repeat (4) begin
            @(negedge clk);
            chk("rw_idle_wbit", o_wbit, 1'b0);
        end

        // Reset asserted while a word is offered: the word must not be taken.
        @(posedge clk);
        #1;
        v0 = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("ra_ready0", r0, 1'b0);
        @(posedge clk);
        #1;
        v0 = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("ra_wbit", o_wbit, 1'b0);
        chk("ra_ptr0", o_ptr0, CH0_BASE);

        // Random traffic against the model.
        hw_reset(1'b0);
        model_reset();
        for (int i = 0; i < 1000; i++) step(0);
        for (int i = 0; i < 12; i++) step(2);
        chk("no_loss_count", cnt[0] + cnt[1], gen_cnt);
        chk("no_pending", {pv[0], pv[1]}, 2'b00);

        // Channel 1 streams across its whole region and wraps once.
        hw_reset(1'b0);
        model_reset();
        n = 0;
        while ((cnt[1] < CH1_LAST - CH1_BASE + 2 || cyc <= acc_cyc + 2) && n < 30000) begin
            step(n < 3 * (CH1_LAST - CH1_BASE + 2) ? 1 : 2);
            n++;
        end
        chk("wrap_bound", n < 30000, 1'b1);
        chk("wrap1_pulses", wrap1_seen, 1);
        chk("wrap_last_addr", o_address, CH1_BASE);
        chk("wrap_ptr0", o_ptr0, CH0_BASE);
        chk("wrap_ptr1", o_ptr1, CH1_BASE + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
